pulse_seq_gen: RTL and testbench

- Upstream timing stage for the per-column switch drivers (in15-style switch controllers).
- On a start request in training mode, generates a train of N programming pulses.
- Each pulse is a switch-setup phase, an active pulse phase and an inter-pulse gap.
- Publishes the phase as the 2-bit pulse_state bus consumed by switch controllers (1/2 = switch closed, 3 = switch open, 0 = hold).
- One instance per pulse channel (the "17" and "27" channels).

---
 rtl/pulse_seq_pkg.sv | 12 +
 rtl/pulse_seq_gen_phase_timer.sv | 26 ++
 rtl/pulse_seq_gen.sv | 182 ++++++++++++++++++
 tb/tb_pulse_seq_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared phase codes and system-mode constants for the pulse sequencer and the
// switch controllers that consume its pulse_state bus.
package pulse_seq_pkg;

    localparam logic [1:0] PS_IDLE  = 2'd0;
    localparam logic [1:0] PS_SETUP = 2'd1;
    localparam logic [1:0] PS_PULSE = 2'd2;
    localparam logic [1:0] PS_GAP   = 2'd3;

    localparam logic [2:0] SYS_TRAIN = 3'd2;

endpackage

// File: rtl/pulse_seq_gen_phase_timer.sv
// Loadable down-counter timing one phase; expire_c is high on the phase's last cycle.
module pulse_seq_gen_phase_timer #(
    parameter int unsigned WIDTH_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH_W-1:0] load_val,
    output logic               expire_c
);

    logic [WIDTH_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH_W'(1);
        end
    end

    assign expire_c = (cnt_q == WIDTH_W'(1));

endmodule

// File: rtl/pulse_seq_gen.sv
// Programming-pulse train generator: SETUP / PULSE / GAP phases repeated pulse_num times.
// Optional sticky abort flag output enabled by PULSE_SEQ_GEN_ABORT_FLAG_EN.
module pulse_seq_gen
    import pulse_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned WIDTH_W   = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_state,
    input  logic [2:0]         system_state,
    input  logic               start,
    input  logic [WIDTH_W-1:0] pulse_width,
    input  logic [WIDTH_W-1:0] gap_width,
    input  logic [CNT_W-1:0]   pulse_num,
    output logic [1:0]         pulse_state,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pulse_idx
`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
    ,
    output logic               aborted
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH_W-1:0] pw_q, gw_q;
    logic [CNT_W-1:0]   num_q;
    logic               run_ok_c;
    logic               accept_c, abort_c, idx_inc_c, more_c;
    logic               load_c, expire_c;
    logic [WIDTH_W-1:0] load_val_c;
    logic [1:0]         ps_d;

    // Zero-length phases still occupy one cycle.
    function automatic logic [WIDTH_W-1:0] at_least_one(input logic [WIDTH_W-1:0] v);
        return (v == '0) ? WIDTH_W'(1) : v;
    endfunction

    assign run_ok_c = key_state && (system_state == SYS_TRAIN);
    assign more_c   = ({1'b0, pulse_idx} + (CNT_W + 1)'(1)) < {1'b0, num_q};

    pulse_seq_gen_phase_timer #(.WIDTH_W(WIDTH_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .load_val (load_val_c),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, phase-timer reload and control strobes.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        load_val_c = '0;
        accept_c   = 1'b0;
        abort_c    = 1'b0;
        idx_inc_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && run_ok_c) begin
                    accept_c = 1'b1;
                    if (pulse_num != '0) begin
                        state_d    = ST_SETUP;
                        load_c     = 1'b1;
                        load_val_c = WIDTH_W'(SETUP_CYC);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                if (expire_c) begin
                    state_d    = ST_PULSE;
                    load_c     = 1'b1;
                    load_val_c = pw_q;
                end
            end
            ST_PULSE: begin
                if (expire_c) begin
                    state_d    = ST_GAP;
                    load_c     = 1'b1;
                    load_val_c = gw_q;
                end
            end
            ST_GAP: begin
                if (expire_c) begin
                    if (more_c) begin
                        state_d    = ST_SETUP;
                        idx_inc_c  = 1'b1;
                        load_c     = 1'b1;
                        load_val_c = WIDTH_W'(SETUP_CYC);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Losing the enable or leaving training mode overrides everything else.
        if (state_q != ST_IDLE && !run_ok_c) begin
            state_d   = ST_IDLE;
            abort_c   = 1'b1;
            load_c    = 1'b0;
            idx_inc_c = 1'b0;
        end
    end

    always_comb begin
        ps_d = PS_IDLE;
        case (state_d)
            ST_SETUP: ps_d = PS_SETUP;
            ST_PULSE: ps_d = PS_PULSE;
            ST_GAP:   ps_d = PS_GAP;
            ST_DONE:  ps_d = PS_GAP;
            default:  ps_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pw_q  <= '0;
            gw_q  <= '0;
            num_q <= '0;
        end else if (accept_c) begin
            pw_q  <= at_least_one(pulse_width);
            gw_q  <= at_least_one(gap_width);
            num_q <= pulse_num;
        end
    end

    // Outputs registered from the next-state decode so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_state <= PS_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_idx   <= '0;
        end else begin
            pulse_state <= ps_d;
            busy        <= (state_d != ST_IDLE);
            done        <= (state_d == ST_DONE);
            if (accept_c || abort_c) begin
                pulse_idx <= '0;
            end else if (idx_inc_c) begin
                pulse_idx <= pulse_idx + CNT_W'(1);
            end
        end
    end

`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else if (abort_c) begin
            aborted <= 1'b1;
        end else if (accept_c) begin
            aborted <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Self-checking bench for pulse_seq_gen: per-cycle comparison against a queue-based
// expected phase trace built from the train parameters.
module tb_pulse_seq_gen;

    localparam int SETUP_CYC = 4;
    localparam int WIDTH_W   = 16;
    localparam int CNT_W     = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               key_state = 1'b1;
    logic [2:0]         system_state = 3'd2;
    logic               start = 1'b0;
    logic [WIDTH_W-1:0] pulse_width = '0;
    logic [WIDTH_W-1:0] gap_width = '0;
    logic [CNT_W-1:0]   pulse_num = '0;
    logic [1:0]         pulse_state;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   pulse_idx;
`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
    logic               aborted;
`endif

    int errors = 0;
    int checks = 0;
    int q_ps[$];
    int q_idx[$];
    int q_done[$];

    pulse_seq_gen #(.SETUP_CYC(SETUP_CYC), .WIDTH_W(WIDTH_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_state    (key_state),
        .system_state (system_state),
        .start        (start),
        .pulse_width  (pulse_width),
        .gap_width    (gap_width),
        .pulse_num    (pulse_num),
        .pulse_state  (pulse_state),
        .busy         (busy),
        .done         (done),
        .pulse_idx    (pulse_idx)
`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
        ,
        .aborted      (aborted)
`endif
    );

    always #5 clk = ~clk;

    // Expected trace: one entry per cycle from start+1 through the done cycle.
    task automatic build(input int w, input int g, input int n);
        int we, ge;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        q_ps.delete(); q_idx.delete(); q_done.delete();
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < SETUP_CYC; k++) begin q_ps.push_back(1); q_idx.push_back(p); q_done.push_back(0); end
            for (int k = 0; k < we; k++)        begin q_ps.push_back(2); q_idx.push_back(p); q_done.push_back(0); end
            for (int k = 0; k < ge; k++)        begin q_ps.push_back(3); q_idx.push_back(p); q_done.push_back(0); end
        end
        q_ps.push_back(3); q_idx.push_back((n == 0) ? 0 : n - 1); q_done.push_back(1);
    endtask

    // Runs one train; abort_at >= 0 drops run_ok after that trace entry (kind 0: key, 1: mode).
    task automatic run_seq(input int w, input int g, input int n, input int abort_at,
                           input int abort_kind, input bit disturb);
        bit did_abort;
        did_abort = 1'b0;
        build(w, g, n);
        @(negedge clk);
        pulse_width = WIDTH_W'(w); gap_width = WIDTH_W'(g); pulse_num = CNT_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < q_ps.size(); i++) begin
            checks += 4;
            if (pulse_state !== 2'(q_ps[i])) begin
                errors++; $display("FAIL pulse_state w=%0d g=%0d n=%0d cyc=%0d: got %0d exp %0d", w, g, n, i, pulse_state, q_ps[i]);
            end
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy w=%0d g=%0d n=%0d cyc=%0d: got %0b exp 1", w, g, n, i, busy);
            end
            if (done !== 1'(q_done[i])) begin
                errors++; $display("FAIL done w=%0d g=%0d n=%0d cyc=%0d: got %0b exp %0d", w, g, n, i, done, q_done[i]);
            end
            if (pulse_idx !== CNT_W'(q_idx[i])) begin
                errors++; $display("FAIL pulse_idx w=%0d g=%0d n=%0d cyc=%0d: got %0d exp %0d", w, g, n, i, pulse_idx, q_idx[i]);
            end
`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
            if (i == 0) begin
                checks++;
                if (aborted !== 1'b0) begin
                    errors++; $display("FAIL aborted_clear_on_start: got %0b exp 0", aborted);
                end
            end
`endif
            if (disturb && i == 1) begin
                start = 1'b1; pulse_width = WIDTH_W'(9); gap_width = WIDTH_W'(7); pulse_num = CNT_W'(n + 3);
            end
            if (disturb && i == 2) start = 1'b0;
            if (i == abort_at) begin
                if (abort_kind == 0) key_state = 1'b0; else system_state = 3'd3;
                did_abort = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        checks += 3;
        if (pulse_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL end_idle w=%0d g=%0d n=%0d: got ps=%0d busy=%0b done=%0b exp 0/0/0", w, g, n, pulse_state, busy, done);
        end
        if (did_abort) begin
            checks++;
            if (pulse_idx !== '0) begin
                errors++; $display("FAIL abort_idx: got %0d exp 0", pulse_idx);
            end
`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
            checks++;
            if (aborted !== 1'b1) begin
                errors++; $display("FAIL aborted_set: got %0b exp 1", aborted);
            end
`endif
            key_state = 1'b1; system_state = 3'd2;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks += 2;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL post_abort_quiet: got done=%0b busy=%0b exp 0/0", done, busy);
                end
`ifdef PULSE_SEQ_GEN_ABORT_FLAG_EN
                if (aborted !== 1'b1) begin
                    errors++; $display("FAIL aborted_sticky: got %0b exp 1", aborted);
                end
`else
                if (pulse_state !== 2'd0) begin
                    errors++; $display("FAIL post_abort_ps: got %0d exp 0", pulse_state);
                end
`endif
            end
        end
        if (disturb) begin
            pulse_width = WIDTH_W'(w); gap_width = WIDTH_W'(g); pulse_num = CNT_W'(n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 4;
        if (pulse_state !== 2'd0) begin errors++; $display("FAIL reset_ps: got %0d exp 0", pulse_state); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %0b exp 0", done); end
        if (pulse_idx !== '0)     begin errors++; $display("FAIL reset_idx: got %0d exp 0", pulse_idx); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pulse_state !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ps=%0d busy=%0b exp 0/0", pulse_state, busy);
        end
    endtask

    task automatic test_basic();
        run_seq(3, 2, 2, -1, 0, 1'b0);
        run_seq(1, 5, 3, -1, 0, 1'b0);
    endtask

    task automatic test_zero_cases();
        run_seq(3, 2, 0, -1, 0, 1'b0);
        run_seq(0, 0, 2, -1, 0, 1'b0);
    endtask

    task automatic test_abort();
        // One cycle into the second PULSE phase.
        run_seq(3, 2, 2, SETUP_CYC + 3 + 2 + SETUP_CYC + 1, 0, 1'b0);
    endtask

    task automatic test_mode_gating();
        system_state = 3'd1;
        @(negedge clk); pulse_width = 16'd3; gap_width = 16'd2; pulse_num = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pulse_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pulse_idx !== '0) begin
                errors++; $display("FAIL mode_gate: got ps=%0d busy=%0b done=%0b idx=%0d exp all 0", pulse_state, busy, done, pulse_idx);
            end
            @(negedge clk);
        end
        system_state = 3'd2;
        key_state = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b0 || pulse_state !== 2'd0) begin
            errors++; $display("FAIL key_gate: got ps=%0d busy=%0b exp 0/0", pulse_state, busy);
        end
        key_state = 1'b1;
        // Mode change 2->3 in the middle of the first GAP.
        run_seq(3, 4, 2, SETUP_CYC + 3 + 1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq(3, 2, 2, -1, 0, 1'b1);
        run_seq(2, 1, 1, -1, 0, 1'b0);
        run_seq(0, 0, 255, -1, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        int budget;
        @(negedge clk); pulse_width = 16'd3; gap_width = 16'd2; pulse_num = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = 0;
        while (pulse_state !== 2'd2 && budget < 50) begin
            @(negedge clk); budget++;
        end
        checks++;
        if (budget >= 50) begin
            errors++; $display("FAIL async_wait_pulse: got ps=%0d exp 2 within 50 cycles", pulse_state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pulse_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pulse_idx !== '0) begin
            errors++; $display("FAIL async_reset: got ps=%0d busy=%0b done=%0b idx=%0d exp all 0", pulse_state, busy, done, pulse_idx);
        end
        @(negedge clk); rst_n = 1'b1;
        run_seq(3, 2, 2, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int w, g, n, len, ab;
            w = int'($urandom_range(0, 5));
            g = int'($urandom_range(0, 5));
            n = int'($urandom_range(0, 4));
            len = (n == 0) ? 1 : n * (SETUP_CYC + ((w == 0) ? 1 : w) + ((g == 0) ? 1 : g)) + 1;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_seq(w, g, n, ab, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cases();
        test_abort();
        test_mode_gating();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
